hazard_ctrl: RTL

Pipeline hazard controller for the 5-stage MIPS core. It sequences the forwarding datapath by deciding, every cycle, whether the IF/ID front end advances, stalls, bubbles or flushes. It covers load-use hazards, branch/JR operand dependencies resolved in ID, taken-branch redirects and I/D-cache miss freezes. It also keeps saturating performance counters and sits beside the forwarding unit in the ID stage.

---
 rtl/hazard_ctrl.sv | 117 +++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: decides each cycle whether IF/ID advances,
// stalls, bubbles or flushes, freezes the back end on cache misses, and counts events.
//
// state  | meaning
// RUN    | normal issue; hazards and taken-branch flushes are evaluated here
// STALL2 | second forced stall cycle of a branch that depends on a load in EX
// MISS   | I- or D-cache miss in progress; whole pipe frozen
module hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] iRs_RegD,
  input  logic [REG_W-1:0] iRt_RegD,
  input  logic             iUseRt_RegD,
  input  logic             iBranch_RegD,
  input  logic             iJr_RegD,
  input  logic             iTaken_RegD,
  input  logic             iRegWrite_RegE,
  input  logic             iMemRead_RegE,
  input  logic [REG_W-1:0] iwsel_RegE,
  input  logic             iMemRead_RegM,
  input  logic [REG_W-1:0] iwsel_RegM,
  input  logic             iICache_stall,
  input  logic             iDCache_stall,
  input  logic             iClrCnt,
  output logic             oStall_PC,
  output logic             oStall_IFID,
  output logic             oBubble_IDEX,
  output logic             oFlush_IFID,
  output logic             oFreeze,
  output logic [1:0]       oState,
  output logic [CNT_W-1:0] oStallCnt,
  output logic [CNT_W-1:0] oMissCnt,
  output logic [CNT_W-1:0] oFlushCnt
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL2 = 2'd1,
    MISS   = 2'd2
  } state_t;

  state_t state;
  logic   stall2Pend;

  logic hitERs, hitERt, hitMRs, hitMRt;
  logic readsInId, loadUse, brDepE, brALU, brLD, brM, hazard, miss;
  logic effStall2, effRun, hazStall, doFlush;

  always_comb begin
    hitERs = (iRs_RegD != '0) && (iRs_RegD == iwsel_RegE) && iRegWrite_RegE;
    hitERt = (iRt_RegD != '0) && (iRt_RegD == iwsel_RegE) && iRegWrite_RegE && iUseRt_RegD;
    hitMRs = (iRs_RegD != '0) && (iRs_RegD == iwsel_RegM) && iMemRead_RegM;
    hitMRt = (iRt_RegD != '0) && (iRt_RegD == iwsel_RegM) && iMemRead_RegM && iUseRt_RegD;

    // JR only reads rs in ID; BEQ/BNE compare both operands there.
    readsInId = iBranch_RegD | iJr_RegD;
    loadUse   = iMemRead_RegE & (hitERs | hitERt);
    brDepE    = readsInId & (hitERs | (hitERt & iBranch_RegD));
    brALU     = brDepE & ~iMemRead_RegE;
    brLD      = brDepE & iMemRead_RegE;
    brM       = readsInId & (hitMRs | (hitMRt & iBranch_RegD));
    hazard    = loadUse | brALU | brLD | brM;
    miss      = iICache_stall | iDCache_stall;

    // Leaving MISS resumes a pending second stall in the same cycle.
    effStall2 = ~miss & ((state == STALL2) | ((state == MISS) & stall2Pend));
    effRun    = ~miss & ~effStall2;
    hazStall  = effRun & hazard;
    doFlush   = effRun & ~hazard & iTaken_RegD;
  end

  assign oFreeze      = rst_n & miss;
  assign oStall_PC    = rst_n & (miss | effStall2 | hazStall);
  assign oStall_IFID  = rst_n & (miss | effStall2 | hazStall);
  assign oBubble_IDEX = rst_n & (effStall2 | hazStall);
  assign oFlush_IFID  = rst_n & doFlush;
  assign oState       = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      stall2Pend <= 1'b0;
    end else if (miss) begin
      state <= MISS;
    end else if (effStall2) begin
      state      <= RUN;
      stall2Pend <= 1'b0;
    end else if (hazStall && brLD) begin
      state      <= STALL2;
      stall2Pend <= 1'b1;
    end else begin
      state <= RUN;
    end
  end

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oStallCnt <= '0;
      oMissCnt  <= '0;
      oFlushCnt <= '0;
    end else if (iClrCnt) begin
      oStallCnt <= '0;
      oMissCnt  <= '0;
      oFlushCnt <= '0;
    end else begin
      if ((effStall2 || hazStall) && oStallCnt != CNT_MAX) oStallCnt <= oStallCnt + 1'b1;
      if (miss && oMissCnt != CNT_MAX)                     oMissCnt  <= oMissCnt + 1'b1;
      if (doFlush && oFlushCnt != CNT_MAX)                 oFlushCnt <= oFlushCnt + 1'b1;
    end
  end

endmodule
